// File: rtl/lcs_pkg.sv
// Shared types and constants for the LCS frame transmitter.
// LCS_TX_PARITY_EN selects the 11-bit character with an even-parity bit.
package lcs_pkg;

    localparam int LCS_ADDR_W = 9;
    localparam int LCS_DATA_W = 8;
    localparam logic LCS_LINE_IDLE = 1'b1;
    localparam logic [LCS_DATA_W-1:0] LCS_TIMEOUT_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        ACKLOW = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } lcs_state_t;

`ifdef LCS_TX_PARITY_EN
    localparam int LCS_CHAR_W = 11;

    function automatic logic lcs_even_parity(input logic [LCS_DATA_W-1:0] data);
        return ^data;
    endfunction

    // Character is sent from bit 0 upward: start, data LSB first, parity, stop.
    function automatic logic [LCS_CHAR_W-1:0] lcs_make_char(input logic [LCS_DATA_W-1:0] data);
        return {1'b1, lcs_even_parity(data), data, 1'b0};
    endfunction
`else
    localparam int LCS_CHAR_W = 10;

    function automatic logic [LCS_CHAR_W-1:0] lcs_make_char(input logic [LCS_DATA_W-1:0] data);
        return {1'b1, data, 1'b0};
    endfunction
`endif

endpackage

// File: rtl/lcs_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module lcs_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/lcs_frame_tx.sv
// LCS frame sequencer: requests each byte of a frame from the answer stage and
// shifts it onto tx_line one bit per tx_tick. LCS_TX_PARITY_EN adds even parity.
module lcs_frame_tx
    import lcs_pkg::*;
#(
    parameter int                    FRAME_LEN   = 256,
    parameter logic [LCS_ADDR_W-1:0] BASE_ADDR   = 9'd0,
    parameter int                    ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_tick,
    input  logic                  start,
    input  logic                  ack,
    input  logic [LCS_DATA_W-1:0] data_in,
    output logic                  req,
    output logic [LCS_ADDR_W-1:0] addr,
    output logic                  tx_line,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  ack_err
);

    localparam int                    TO_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]       TO_ONE   = TO_W'(1);
    localparam logic [LCS_ADDR_W-1:0] LAST_IDX = LCS_ADDR_W'(FRAME_LEN - 1);
    localparam logic [3:0]            CHAR_END = 4'(LCS_CHAR_W);

    lcs_state_t              state_r;
    logic                    ack_sync_s;
    logic                    ack_prev_r;
    logic                    ack_rise_s;
    logic [LCS_CHAR_W-1:0]   shift_r;
    logic [3:0]              bit_cnt_r;
    logic [LCS_ADDR_W-1:0]   idx_r;
    logic [TO_W-1:0]         to_cnt_r;
    logic                    req_r;
    logic [LCS_ADDR_W-1:0]   addr_r;
    logic                    tx_line_r;
    logic                    busy_r;
    logic                    frame_done_r;
    logic                    ack_err_r;

    lcs_sync2 u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack),
        .q   (ack_sync_s)
    );

    // Previous synchronized ack, for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_prev_r <= 1'b0;
        end else begin
            ack_prev_r <= ack_sync_s;
        end
    end

    assign ack_rise_s = ack_sync_s & ~ack_prev_r;

    // Frame sequencer; bit_cnt_r counts ticks in SHIFT, CHAR_END marks the tick that ends the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            shift_r      <= {LCS_CHAR_W{1'b1}};
            bit_cnt_r    <= 4'd0;
            idx_r        <= {LCS_ADDR_W{1'b0}};
            to_cnt_r     <= {TO_W{1'b0}};
            req_r        <= 1'b0;
            addr_r       <= BASE_ADDR;
            tx_line_r    <= LCS_LINE_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            ack_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    frame_done_r <= 1'b0;
                    if (start) begin
                        busy_r    <= 1'b1;
                        ack_err_r <= 1'b0;
                        idx_r     <= {LCS_ADDR_W{1'b0}};
                        addr_r    <= BASE_ADDR;
                        to_cnt_r  <= {TO_W{1'b0}};
                        req_r     <= 1'b1;
                        state_r   <= REQ;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                REQ: begin
                    if (ack_rise_s) begin
                        shift_r <= lcs_make_char(data_in);
                        req_r   <= 1'b0;
                        state_r <= ACKLOW;
                    end else if (to_cnt_r == TO_LAST) begin
                        shift_r   <= lcs_make_char(LCS_TIMEOUT_BYTE);
                        ack_err_r <= 1'b1;
                        req_r     <= 1'b0;
                        state_r   <= ACKLOW;
                    end else begin
                        to_cnt_r  <= to_cnt_r + TO_ONE;
                    end
                end
                ACKLOW: begin
                    if (!ack_sync_s) begin
                        bit_cnt_r <= 4'd0;
                        state_r   <= SHIFT;
                    end else begin
                        state_r   <= ACKLOW;
                    end
                end
                SHIFT: begin
                    if (tx_tick) begin
                        if (bit_cnt_r == CHAR_END) begin
                            if (idx_r == LAST_IDX) begin
                                frame_done_r <= 1'b1;
                                state_r      <= DONE;
                            end else begin
                                idx_r    <= idx_r + 9'd1;
                                addr_r   <= BASE_ADDR + idx_r + 9'd1;
                                to_cnt_r <= {TO_W{1'b0}};
                                req_r    <= 1'b1;
                                state_r  <= REQ;
                            end
                        end else begin
                            tx_line_r <= shift_r[0];
                            shift_r   <= {1'b1, shift_r[LCS_CHAR_W-1:1]};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    req_r     <= 1'b0;
                    tx_line_r <= LCS_LINE_IDLE;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign req        = req_r;
    assign addr       = addr_r;
    assign tx_line    = tx_line_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign ack_err    = ack_err_r;

endmodule

// File: tb/tb_lcs_frame_tx.sv
// Randomized bench for lcs_frame_tx: a responder model feeds bytes, a UART-style
// decoder and per-cycle frame model check the serial output and handshake.
module tb_lcs_frame_tx;

    localparam int FRAME_LEN = 4;
    localparam int BASE      = 510;
    localparam int ACK_TO    = 64;
`ifdef LCS_TX_PARITY_EN
    localparam int CHARW   = 11;
    localparam int A5_CHAR = 32'b10101001010;
`else
    localparam int CHARW   = 10;
    localparam int A5_CHAR = 32'b1101001010;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_tick;
    logic       start;
    logic       ack;
    logic [7:0] data_in;
    logic       req;
    logic [8:0] addr;
    logic       tx_line;
    logic       busy;
    logic       frame_done;
    logic       ack_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  dir_bytes[$];
    bit          dir_noack[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  obs_bytes[$];
    int          obs_addr[$];
    bit          rand_noack_en = 1'b0;
    bit          cur_noack = 1'b0;
    int          cur_delay = 0;
    int          frames_done = 0;
    int          frame_bytes = 0;
    int          req_idx = 0;
    bit          dec_act = 1'b0;
    int          dec_n = 0;
    logic [10:0] first_char = 11'd0;

    lcs_frame_tx #(
        .FRAME_LEN   (FRAME_LEN),
        .BASE_ADDR   (9'd510),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_tick    (tx_tick),
        .start      (start),
        .ack        (ack),
        .data_in    (data_in),
        .req        (req),
        .addr       (addr),
        .tx_line    (tx_line),
        .busy       (busy),
        .frame_done (frame_done),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bit strobe with random spacing.
    initial begin
        tx_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_tick = ($urandom_range(0, 1) == 1);
        end
    end

    // Answer-stage model: ack after a random delay, or never when a timeout is wanted.
    initial begin : responder
        int st;
        int cnt;
        logic [7:0] b;
        st = 0;
        cnt = 0;
        ack = 1'b0;
        data_in = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                st = 0;
                ack = 1'b0;
            end else begin
                case (st)
                    0: if (req) begin
                        if (dir_noack.size() > 0) cur_noack = dir_noack.pop_front();
                        else cur_noack = rand_noack_en && ($urandom_range(0, 5) == 0);
                        if (cur_noack) begin
                            exp_bytes.push_back(8'hFF);
                            st = 3;
                        end else begin
                            cur_delay = $urandom_range(1, 8);
                            cnt = cur_delay;
                            st = 1;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            b = (dir_bytes.size() > 0) ? dir_bytes.pop_front() : 8'($urandom);
                            data_in = b;
                            ack = 1'b1;
                            exp_bytes.push_back(b);
                            st = 2;
                        end
                    end
                    2: if (!req) begin
                        cnt = $urandom_range(0, 3);
                        st = 4;
                    end
                    3: if (!req) st = 0;
                    4: begin
                        if (cnt == 0) begin
                            ack = 1'b0;
                            st = 0;
                        end else begin
                            cnt--;
                        end
                    end
                    default: st = 0;
                endcase
            end
        end
    end

    // Frame model and serial decoder, sampled on the falling edge.
    initial begin : monitor
        bit req_prev;
        bit fd_prev;
        bit in_frame;
        bit exp_err;
        int req_len;
        int last_stop;
        logic [10:0] dec_char;
        logic [7:0] b;
        req_prev = 1'b0; fd_prev = 1'b0; in_frame = 1'b0; exp_err = 1'b0;
        req_len = 0; last_stop = -100; dec_char = 11'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                req_prev = 1'b0; fd_prev = 1'b0; in_frame = 1'b0; exp_err = 1'b0;
                req_len = 0; dec_act = 1'b0; dec_n = 0; frame_bytes = 0; req_idx = 0;
                exp_bytes.delete();
            end else begin
                if (req && !req_prev) begin
                    check("addr_at_req", addr, (BASE + req_idx) % 512);
                    obs_addr.push_back(int'(addr));
                    req_idx++;
                    req_len = 1;
                end else if (req) begin
                    check("addr_hold", addr, (BASE + req_idx - 1) % 512);
                    req_len++;
                end else if (req_prev) begin
                    check("req_len", req_len, cur_noack ? ACK_TO : cur_delay + 3);
                    if (cur_noack) exp_err = 1'b1;
                end
                check("ack_err", ack_err, exp_err);
                check("busy", busy, in_frame);
                if (!busy) check("idle_line", tx_line, 1);

                if (tx_tick) begin
                    if (!dec_act) begin
                        if (tx_line == 1'b0) begin
                            dec_act = 1'b1;
                            dec_n = 0;
                            dec_char = 11'd0;
                        end
                    end else begin
                        dec_n++;
                        dec_char[dec_n] = tx_line;
                        if (dec_n == CHARW - 1) begin
                            b = dec_char[8:1];
                            check("stop_bit", dec_char[CHARW-1], 1);
`ifdef LCS_TX_PARITY_EN
                            check("parity_bit", dec_char[9], ^b);
`endif
                            if (exp_bytes.size() == 0) check("byte_unexpected", b, -1);
                            else check("byte", b, exp_bytes.pop_front());
                            if (frame_bytes == 0) first_char = dec_char;
                            obs_bytes.push_back(b);
                            frame_bytes++;
                            last_stop = cyc;
                            dec_act = 1'b0;
                        end
                    end
                end

                if (frame_done) begin
                    check("done_single", fd_prev, 0);
                    check("done_timing", cyc - last_stop, 1);
                    check("done_bytes", frame_bytes, FRAME_LEN);
                    check("done_reqs", req_idx, FRAME_LEN);
                    check("done_pending", exp_bytes.size(), 0);
                    check("done_in_frame", in_frame, 1);
                    frames_done++;
                    in_frame = 1'b0;
                end
                if (start && !busy) begin
                    in_frame = 1'b1;
                    exp_err = 1'b0;
                    req_idx = 0;
                    frame_bytes = 0;
                end
                req_prev = req;
                fd_prev = frame_done;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input bit extra);
        int fd0;
        int i;
        obs_addr.delete();
        obs_bytes.delete();
        fd0 = frames_done;
        pulse_start();
        if (extra) begin
            repeat (20) @(posedge clk);
            pulse_start();
        end
        i = 0;
        while (frames_done == fd0 && i < 20000) begin
            @(posedge clk);
            i++;
        end
        check("frame_done_seen", frames_done, fd0 + 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int exp_a[4];
        int exp_b[4];
        int fd0;
        int i;
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", req, 0);
        check("rst_addr", addr, BASE);
        check("rst_line", tx_line, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", ack_err, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Fixed bytes, address wrap past 511.
        dir_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(1'b0);
        exp_a = '{510, 511, 0, 1};
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check("t1_naddr", obs_addr.size(), 4);
        check("t1_nbytes", obs_bytes.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_addr.size()) check("t1_addr", obs_addr[k], exp_a[k]);
            if (k < obs_bytes.size()) check("t1_byte", obs_bytes[k], exp_b[k]);
        end
        check("t1_ack_err", ack_err, 0);

        // Exact character for 0xA5.
        dir_bytes = '{8'hA5, 8'h01, 8'h02, 8'h03};
        run_frame(1'b0);
        check("a5_char", first_char, A5_CHAR);

        // Timeout on the second byte.
        dir_noack = '{1'b0, 1'b1};
        run_frame(1'b0);
        check("t3_err_set", ack_err, 1);
        check("t3_nbytes", obs_bytes.size(), 4);
        if (obs_bytes.size() > 1) check("t3_sub_byte", obs_bytes[1], 8'hFF);
        repeat (30) @(posedge clk);
        #1;
        check("t3_err_sticky", ack_err, 1);
        run_frame(1'b0);
        check("t3_err_cleared", ack_err, 0);

        // Start pulsed while busy is dropped.
        fd0 = frames_done;
        run_frame(1'b1);
        repeat (60) @(posedge clk);
        #1;
        check("t4_one_done", frames_done, fd0 + 1);
        check("t4_idle", busy, 0);

        // Reset during data bit 4 of byte 2.
        dir_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        i = 0;
        while (!(frame_bytes == 1 && dec_act && dec_n == 4) && i < 5000) begin
            @(posedge clk);
            i++;
        end
        check("t5_reach_bit4", int'(i < 5000), 1);
        #1;
        rst = 1'b0;
        #1;
        check("t5_line_async", tx_line, 1);
        check("t5_req_async", req, 0);
        check("t5_busy_async", busy, 0);
        repeat (3) @(posedge clk);
        dir_bytes.delete();
        dir_noack.delete();
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        dir_bytes = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        run_frame(1'b0);
        check("t5_naddr", obs_addr.size(), 4);
        if (obs_addr.size() > 0) check("t5_first_addr", obs_addr[0], BASE);
        if (obs_bytes.size() > 0) check("t5_first_byte", obs_bytes[0], 8'h5A);

        // Random frames with occasional timeouts and stray starts.
        rand_noack_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            run_frame(bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
